hpi_bus_master: RTL and testbench

//  Parametrised host-port (HPI) bus master between on-chip software logic and the
//  USB OTG controller. Replaces per-cycle pass-through with a transaction engine.

---
 rtl/hpi_bus_master.sv | 169 ++++++++++++++++
 tb/tb_hpi_bus_master.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_bus_master.sv
// HPI host-port bus master: turns one valid/ready request into a timed CS/RD/WR strobe
// sequence on the OTG controller bus, and synchronises OTG_INT into level/edge interrupts.
module hpi_bus_master #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int INT_SYNC   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              irq_level,
    output logic              irq_pulse,
    inout  wire  [DATA_W-1:0] OTG_DATA,
    output logic [ADDR_W-1:0] OTG_ADDR,
    output logic              OTG_RD_N,
    output logic              OTG_WR_N,
    output logic              OTG_CS_N,
    output logic              OTG_RST_N,
    input  logic              OTG_INT
);

    localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_SH > STROBE_CYC) ? MAX_SH : STROBE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    if (STROBE_CYC < 1) begin : g_bad_strobe
        $error("hpi_bus_master: STROBE_CYC must be at least 1");
    end
    if (INT_SYNC < 2) begin : g_bad_sync
        $error("hpi_bus_master: INT_SYNC must be at least 2");
    end

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic                drive_en;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_cap;
    logic [INT_SYNC-1:0] int_sync;
    logic                last_cnt;
    logic                strobe_end;
    logic                done;
    logic [DATA_W-1:0]   done_rdata;

    assign req_ready = (state == S_IDLE) && !Reset;
    assign OTG_RST_N = ~Reset;
    assign OTG_DATA  = drive_en ? wdata_q : {DATA_W{1'bz}};
    assign irq_level = int_sync[INT_SYNC-1];

    assign last_cnt   = (cnt == '0);
    assign strobe_end = (state == S_STROBE) && last_cnt;
    assign done       = ((state == S_HOLD) && last_cnt) || (strobe_end && (HOLD_CYC == 0));
    // Without a hold phase the read data is taken straight off the bus at completion.
    assign done_rdata = (state == S_HOLD) ? rdata_cap : OTG_DATA;

    // Transaction data: latched at accept, read data captured at the end of the strobe.
    always_ff @(posedge Clk) begin
        if (req_valid && req_ready) begin
            write_q <= req_write;
            wdata_q <= req_wdata;
        end
        if (strobe_end && !write_q) begin
            rdata_cap <= OTG_DATA;
        end
    end

    // Strobe sequencer: one down-counter shared by the setup, strobe and hold phases.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            drive_en  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            OTG_ADDR  <= '0;
            OTG_CS_N  <= 1'b1;
            OTG_RD_N  <= 1'b1;
            OTG_WR_N  <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        OTG_CS_N <= 1'b0;
                        OTG_ADDR <= req_addr;
                        drive_en <= req_write;
                        if (SETUP_CYC > 0) begin
                            state <= S_SETUP;
                            cnt   <= SETUP_LD;
                        end else begin
                            state    <= S_STROBE;
                            cnt      <= STROBE_LD;
                            OTG_RD_N <= req_write;
                            OTG_WR_N <= ~req_write;
                        end
                    end
                end
                S_SETUP: begin
                    if (last_cnt) begin
                        state    <= S_STROBE;
                        cnt      <= STROBE_LD;
                        OTG_RD_N <= write_q;
                        OTG_WR_N <= ~write_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (last_cnt) begin
                        OTG_RD_N <= 1'b1;
                        OTG_WR_N <= 1'b1;
                        if (HOLD_CYC > 0) begin
                            state <= S_HOLD;
                            cnt   <= HOLD_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!last_cnt) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (done) begin
                state     <= S_IDLE;
                OTG_CS_N  <= 1'b1;
                drive_en  <= 1'b0;
                rsp_valid <= 1'b1;
                if (!write_q) begin
                    rsp_rdata <= done_rdata;
                end
            end
        end
    end

    // Interrupt synchroniser; the pulse is registered so it lines up with irq_level rising.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            int_sync  <= '0;
            irq_pulse <= 1'b0;
        end else begin
            int_sync  <= {int_sync[INT_SYNC-2:0], OTG_INT};
            irq_pulse <= int_sync[INT_SYNC-2] & ~int_sync[INT_SYNC-1];
        end
    end

endmodule

// File: tb/tb_hpi_bus_master.sv
// Directed bench for hpi_bus_master: expected responses are queued at issue time and
// checked by per-instance monitors; bus timing is checked cycle by cycle.
module tb_hpi_bus_master;

    localparam int DW = 16;
    localparam int AW = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          Reset     = 1'b1;
    logic          OTG_INT   = 1'b0;

    // Instance A: default timing
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, irq_level, irq_pulse;
    logic [DW-1:0] rsp_rdata;
    wire  [DW-1:0] OTG_DATA;
    logic [AW-1:0] OTG_ADDR;
    logic          OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N;
    logic          dev_en    = 1'b0;
    logic [DW-1:0] dev_data  = '0;
    assign OTG_DATA = dev_en ? dev_data : {DW{1'bz}};

    // Instance B: no setup, no hold, 3-cycle strobe
    logic          b_req_valid = 1'b0;
    logic          b_req_write = 1'b0;
    logic [AW-1:0] b_req_addr  = '0;
    logic [DW-1:0] b_req_wdata = '0;
    logic          b_req_ready, b_rsp_valid, b_irq_level, b_irq_pulse;
    logic [DW-1:0] b_rsp_rdata;
    wire  [DW-1:0] b_OTG_DATA;
    logic [AW-1:0] b_OTG_ADDR;
    logic          b_OTG_RD_N, b_OTG_WR_N, b_OTG_CS_N, b_OTG_RST_N;
    logic          b_dev_en    = 1'b0;
    logic [DW-1:0] b_dev_data  = '0;
    assign b_OTG_DATA = b_dev_en ? b_dev_data : {DW{1'bz}};

    hpi_bus_master dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .irq_level(irq_level), .irq_pulse(irq_pulse),
        .OTG_DATA(OTG_DATA), .OTG_ADDR(OTG_ADDR), .OTG_RD_N(OTG_RD_N),
        .OTG_WR_N(OTG_WR_N), .OTG_CS_N(OTG_CS_N), .OTG_RST_N(OTG_RST_N),
        .OTG_INT(OTG_INT)
    );

    hpi_bus_master #(.SETUP_CYC(0), .STROBE_CYC(3), .HOLD_CYC(0)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .irq_level(b_irq_level), .irq_pulse(b_irq_pulse),
        .OTG_DATA(b_OTG_DATA), .OTG_ADDR(b_OTG_ADDR), .OTG_RD_N(b_OTG_RD_N),
        .OTG_WR_N(b_OTG_WR_N), .OTG_CS_N(b_OTG_CS_N), .OTG_RST_N(b_OTG_RST_N),
        .OTG_INT(OTG_INT)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        int            at;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    exp_t          ea, eb;
    logic [DW-1:0] last_a = '0;
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    int            c0_main;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitors
    initial forever begin
        @(negedge Clk);
        if (rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_a_unexpected: got rsp_valid at cycle %0d, expected none", cyc);
            end else begin
                ea = qa.pop_front();
                chk("rsp_a_cycle", cyc, ea.at);
                chk("rsp_a_rdata", rsp_rdata, ea.rdata);
            end
        end
    end

    initial forever begin
        @(negedge Clk);
        if (b_rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_b_unexpected: got rsp_valid at cycle %0d, expected none", cyc);
            end else begin
                eb = qb.pop_front();
                chk("rsp_b_cycle", cyc, eb.at);
                chk("rsp_b_rdata", b_rsp_rdata, eb.rdata);
            end
        end
    end

    // Presents a request on instance A and returns the cycle number of the accept cycle.
    task automatic issue_a(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int c0);
        int i;
        @(negedge Clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        i = 0;
        while (!req_ready && i < 20) begin
            @(negedge Clk);
            #1;
            i++;
        end
        chk("issue_ready", req_ready, 1);
        c0 = cyc;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int c0;
        issue_a(1'b1, a, d, c0);
        qa.push_back(exp_t'{last_a, c0 + 5});
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            dev_en   = (k == 5);
            dev_data = '0;
            #1;
            chk("wr_cs_n", OTG_CS_N, (k <= 4) ? 0 : 1);
            chk("wr_wr_n", OTG_WR_N, (k == 2 || k == 3) ? 0 : 1);
            chk("wr_rd_n", OTG_RD_N, 1);
            if (k <= 4) begin
                chk("wr_addr", OTG_ADDR, a);
                chk("wr_data", OTG_DATA, d);
            end else begin
                chk("wr_data_released", OTG_DATA, 0);
                chk("wr_ready_done", req_ready, 1);
            end
            if (k == 2) chk("wr_ready_busy", req_ready, 0);
        end
        dev_en = 1'b0;
    endtask

    // Device drives v only during strobe cycles 2-3 and zero elsewhere, so a wrong
    // sample edge or a block driving the bus both show up.
    task automatic read_a(input logic [AW-1:0] a, input logic [DW-1:0] v);
        int c0;
        issue_a(1'b0, a, '0, c0);
        qa.push_back(exp_t'{v, c0 + 5});
        last_a = v;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            dev_en   = 1'b1;
            dev_data = (k == 2 || k == 3) ? v : '0;
            #1;
            chk("rd_cs_n", OTG_CS_N, (k <= 4) ? 0 : 1);
            chk("rd_rd_n", OTG_RD_N, (k == 2 || k == 3) ? 0 : 1);
            chk("rd_wr_n", OTG_WR_N, 1);
            chk("rd_bus_not_driven", OTG_DATA, dev_data);
            if (k <= 4) chk("rd_addr", OTG_ADDR, a);
        end
        dev_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge Clk);
        dev_en     = 1'b1;
        dev_data   = '0;
        b_dev_en   = 1'b1;
        b_dev_data = '0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_irq_level", irq_level, 0);
        chk("rst_irq_pulse", irq_pulse, 0);
        chk("rst_addr", OTG_ADDR, 0);
        chk("rst_cs_n", OTG_CS_N, 1);
        chk("rst_rd_n", OTG_RD_N, 1);
        chk("rst_wr_n", OTG_WR_N, 1);
        chk("rst_rst_n", OTG_RST_N, 0);
        chk("rst_data_z", OTG_DATA, 0);
        chk("rst_b_ready", b_req_ready, 0);
        chk("rst_b_cs_n", b_OTG_CS_N, 1);
        dev_en   = 1'b0;
        b_dev_en = 1'b0;
        Reset    = 1'b0;
        @(negedge Clk);
        #1;
        chk("post_rst_rst_n", OTG_RST_N, 1);
        chk("post_rst_ready", req_ready, 1);

        // Single write, single read, then a write that must keep the last read data
        write_a(2'b10, 16'hBEEF);
        read_a(2'b01, 16'h1234);
        write_a(2'b00, 16'h0F0F);

        // Back-to-back writes with req_valid held
        @(negedge Clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'b11;
        req_wdata = 16'h0001;
        #1;
        chk("b2b_ready_first", req_ready, 1);
        c0_main = cyc;
        qa.push_back(exp_t'{last_a, c0_main + 5});
        @(posedge Clk);
        #1;
        req_addr  = 2'b00;
        req_wdata = 16'h0002;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            #1;
            chk("b2b_cs_n", OTG_CS_N, (k == 5 || k == 10) ? 1 : 0);
            if (k <= 4) chk("b2b_data1", OTG_DATA, 16'h0001);
            if (k >= 6 && k <= 9) begin
                chk("b2b_data2", OTG_DATA, 16'h0002);
                chk("b2b_addr2", OTG_ADDR, 2'b00);
            end
            if (k == 5) begin
                chk("b2b_ready_second", req_ready, 1);
                qa.push_back(exp_t'{last_a, c0_main + 10});
                @(posedge Clk);
                #1;
                req_valid = 1'b0;
            end
        end

        // Reset in cycle 2 of a write
        issue_a(1'b1, 2'b01, 16'hA5A5, c0_main);
        @(negedge Clk);
        #1;
        chk("rstmid_cs_n_c1", OTG_CS_N, 0);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("rstmid_ready_c2", req_ready, 0);
        @(negedge Clk);
        dev_en   = 1'b1;
        dev_data = '0;
        #1;
        chk("rstmid_cs_n_c3", OTG_CS_N, 1);
        chk("rstmid_wr_n_c3", OTG_WR_N, 1);
        chk("rstmid_data_c3", OTG_DATA, 0);
        chk("rstmid_ready_c3", req_ready, 0);
        chk("rstmid_rdata_c3", rsp_rdata, 0);
        dev_en = 1'b0;
        Reset  = 1'b0;
        last_a = '0;
        @(negedge Clk);
        #1;
        chk("rstmid_ready_c4", req_ready, 1);
        read_a(2'b10, 16'h5A5A);

        // Interrupt synchroniser
        @(negedge Clk);
        #3;
        OTG_INT = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clk);
            #1;
            chk("irq1_level", irq_level, (k >= 2) ? 1 : 0);
            chk("irq1_pulse", irq_pulse, (k == 2) ? 1 : 0);
        end
        #2;
        OTG_INT = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            #1;
            chk("irq_fall_level", irq_level, (k < 2) ? 1 : 0);
            chk("irq_fall_pulse", irq_pulse, 0);
        end
        #2;
        OTG_INT = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            #1;
            chk("irq2_level", irq_level, (k >= 2) ? 1 : 0);
            chk("irq2_pulse", irq_pulse, (k == 2) ? 1 : 0);
        end

        // Instance B: read with no setup/hold, 3-cycle strobe
        @(negedge Clk);
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 2'b11;
        #1;
        chk("b_ready_idle", b_req_ready, 1);
        c0_main = cyc;
        qb.push_back(exp_t'{16'hC3C3, c0_main + 4});
        @(posedge Clk);
        #1;
        b_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            b_dev_en   = 1'b1;
            b_dev_data = (k == 3) ? 16'hC3C3 : 16'h0000;
            #1;
            chk("b_cs_n", b_OTG_CS_N, (k <= 3) ? 0 : 1);
            chk("b_rd_n", b_OTG_RD_N, (k <= 3) ? 0 : 1);
            chk("b_wr_n", b_OTG_WR_N, 1);
            chk("b_bus_not_driven", b_OTG_DATA, b_dev_data);
            if (k <= 3) chk("b_addr", b_OTG_ADDR, 2'b11);
        end
        b_dev_en = 1'b0;

        repeat (3) @(negedge Clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
